// File: rtl/regram_fifo_ctrl.sv
// FIFO controller around a zero-latency-read register RAM: it owns the pointers, occupancy
// and valid/ready handshakes, and it drives the RAM write port and read address.
module regram_fifo_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_DEPTH     = 16,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [$clog2(DATA_DEPTH):0]   count_o,
  output logic                          almost_full_o,
  output logic [$clog2(DATA_DEPTH)-1:0] ram_waddr_o,
  output logic                          ram_we_o,
  output logic [DATA_WIDTH-1:0]         ram_wdata_o,
  output logic [$clog2(DATA_DEPTH)-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_i
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr, rptr, count_reg;
  logic          empty, full, push, pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // Handshake: a word transfers on a cycle where valid and ready are both high and flush_i
  // is low. Ready never depends on the same-cycle valid, and a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o && !flush_i && !rst;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  assign ram_we_o    = push;
  assign ram_waddr_o = wptr[AW-1:0];
  assign ram_wdata_o = in_data_i;
  assign ram_raddr_o = rptr[AW-1:0];
  assign out_data_o  = ram_rdata_i;

  assign count_o       = count_reg;
  assign almost_full_o = (count_reg >= PW'(ALMOST_FULL_TH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count_reg <= '0;
    end else if (flush_i) begin
      wptr      <= '0;
      rptr      <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + PW'(1);
        2'b01:   count_reg <= count_reg - PW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_count_ptr: assert property (@(posedge clk) disable iff (rst)
    count_reg == PW'(wptr - rptr));
  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count_reg <= PW'(DATA_DEPTH));
  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_data_o));
`endif

endmodule

// File: tb/tb_regram_fifo_ctrl.sv
// Bench for regram_fifo_ctrl: a vector table for reset/fill/full, hand-written sequences for
// the flush, streaming and async-reset cases, and an expected-data queue for ordering.
module tb_regram_fifo_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AFT = 12;
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [DW-1:0] mem [DEPTH];

  regram_fifo_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ALMOST_FULL_TH(AFT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count), .almost_full_o(almost_full),
    .ram_waddr_o(ram_waddr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
  );

  // Clock and external register RAM (synchronous write, combinational read)
  always #5 clk = ~clk;
  always_ff @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard and reference occupancy
  logic [DW-1:0] exp_q[$];
  int            mcount = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [DW-1:0] data;
    logic          e_ir;
    logic          e_ov;
    int            e_cnt;
    logic          e_af;
    logic          e_we;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, then check pre-edge outputs and update the model.
  task automatic step(input logic iv, input logic ordy, input logic fl, input logic [DW-1:0] d);
    logic do_push, do_pop;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl; in_data = d;
    #1;
    do_push = iv && (mcount != DEPTH) && !fl;
    do_pop  = ordy && (mcount != 0) && !fl;
    chk("count", DW'(count), DW'(mcount));
    chk("in_ready", DW'(in_ready), DW'(mcount != DEPTH));
    chk("out_valid", DW'(out_valid), DW'(mcount != 0));
    chk("almost_full", DW'(almost_full), DW'(mcount >= AFT));
    chk("ram_we", DW'(ram_we), DW'(do_push));
    if (do_pop) begin
      if (exp_q.size() == 0) chk("pop_on_empty_queue", DW'(1), DW'(0));
      else chk("out_data", out_data, exp_q.pop_front());
    end
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (do_push) exp_q.push_back(d);
      mcount = mcount + int'(do_push) - int'(do_pop);
    end
  endtask

  task automatic add_vec(input logic iv, input logic ordy, input logic fl, input logic [DW-1:0] d,
                         input logic ir, input logic ov, input int cnt, input logic af,
                         input logic we);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.data = d;
    v.e_ir = ir; v.e_ov = ov; v.e_cnt = cnt; v.e_af = af; v.e_we = we;
    vecs.push_back(v);
  endtask

  initial begin
    // Vector table: idle after reset, fill to full, held 17th push, full with pop
    for (int i = 0; i < 10; i++) add_vec(0, 0, 0, '0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      add_vec(1, 0, 0, DW'(32'h11 + i), 1, i > 0, i, i >= AFT, 1);
    add_vec(1, 0, 0, 32'h99, 0, 1, 16, 1, 0);
    add_vec(1, 1, 0, 32'h98, 0, 1, 16, 1, 0);
    add_vec(0, 0, 0, '0, 1, 1, 15, 1, 0);

    // Reset values while rst is held
    #2;
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_count", DW'(count), DW'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].data);
      chk("tbl_in_ready", DW'(in_ready), DW'(vecs[i].e_ir));
      chk("tbl_out_valid", DW'(out_valid), DW'(vecs[i].e_ov));
      chk("tbl_count", DW'(count), DW'(vecs[i].e_cnt));
      chk("tbl_almost_full", DW'(almost_full), DW'(vecs[i].e_af));
      chk("tbl_ram_we", DW'(ram_we), DW'(vecs[i].e_we));
    end

    // Drain: expects 0x12..0x20 in order
    for (int i = 0; i < 15; i++) step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    chk("drained_queue", DW'(exp_q.size()), DW'(0));

    // Streaming with random data; count settles at 1 after the first cycle
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, DW'($urandom_range(32'hFFFF, 0)) ^ (DW'(i) << 16));
      if (i > 0) chk("stream_count", DW'(count), DW'(1));
    end
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    // Flush with a concurrent push: the flush-cycle word must never be written
    for (int i = 0; i < 5; i++) step(1, 0, 0, DW'(32'hA0 + i));
    step(1, 1, 1, 32'hEE);
    chk("flush_ram_we", DW'(ram_we), DW'(0));
    step(0, 0, 0, '0);
    chk("post_flush_count", DW'(count), DW'(0));
    chk("post_flush_out_valid", DW'(out_valid), DW'(0));
    step(1, 0, 0, 32'h5A);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    // Asynchronous reset between clock edges with 7 words loaded
    for (int i = 0; i < 7; i++) step(1, 0, 0, DW'(32'hC0 + i));
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hDD;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", DW'(in_ready), DW'(1));
    chk("async_rst_out_valid", DW'(out_valid), DW'(0));
    chk("async_rst_count", DW'(count), DW'(0));
    chk("async_rst_almost_full", DW'(almost_full), DW'(0));
    chk("async_rst_ram_we", DW'(ram_we), DW'(0));
    in_valid = 1'b0;
    exp_q.delete();
    mcount = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 32'hAB);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    chk("final_queue", DW'(exp_q.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
